// File: rtl/conv_pool_stream.sv
// conv_pool_stream: streaming KxK valid-region convolution followed by
// scaling, saturation, optional ReLU and 2x2 stride-2 max pooling.
// Pixels arrive in raster order, one per in_valid cycle. Pooled results
// leave in raster order, qualified by valid.
// Optional feature: define CONV_RELU_EN to clamp negative conv results to 0
// before pooling. Latency is the same in both builds.
// The reset input is active-low, even though it is named "reset".
module conv_pool_stream #(
    parameter int DIM   = 32,
    parameter int K     = 5,
    parameter int PW    = 9,
    parameter int WW    = 8,
    parameter int SHIFT = 0,
    parameter int OW    = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [PW-1:0]         pxl_in,
    input  logic [K*K*WW-1:0]     weights,
    output logic [OW-1:0]         pool_out,
    output logic                  valid,
    output logic                  frame_done
);

    localparam int CD  = DIM - K + 1;
    localparam int NT  = K * K;
    localparam int CW  = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int PP  = PW + WW;
    localparam int SW  = PP + $clog2(NT);
    localparam int PIW = (CD / 2 > 1) ? $clog2(CD / 2) : 1;
    localparam int LB  = (K > 1) ? K - 1 : 1;

    // input position and the window-complete decision derived from it
    logic [CW-1:0] col, row;
    logic [CW-1:0] conv_col, conv_row;
    logic          win_full;

    assign win_full = (row >= CW'(K - 1)) && (col >= CW'(K - 1));
    assign conv_col = col - CW'(K - 1);
    assign conv_row = row - CW'(K - 1);

    // line buffers, sliding window and the column entering the window
    logic [PW-1:0] line_buf [LB][DIM];
    logic [PW-1:0] win      [K][K];
    logic [PW-1:0] new_col  [K];

    // pipeline valid bits and the pool bookkeeping that travels with them
    logic           v0, v1, v2;
    logic           odd_c0, odd_c1, odd_c2;
    logic           odd_r0, odd_r1, odd_r2;
    logic [PIW-1:0] idx0, idx1, idx2;
    logic           last0, last1, last2;

    // arithmetic stages
    logic signed [PP-1:0] prod [NT];
    logic signed [SW-1:0] acc;
    logic signed [SW-1:0] shifted;
    logic signed [OW-1:0] sat;
    logic signed [OW-1:0] conv_s2;

    // pooling state
    logic signed [OW-1:0] hold;
    logic signed [OW-1:0] pool_row_buf [CD/2];
    logic signed [OW-1:0] hmax;
    logic signed [OW-1:0] pmax;

    // raster counters plus stage-0 tags captured alongside the window shift
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col    <= '0;
            row    <= '0;
            v0     <= 1'b0;
            odd_c0 <= 1'b0;
            odd_r0 <= 1'b0;
            idx0   <= '0;
            last0  <= 1'b0;
        end else begin
            v0 <= in_valid && win_full;
            if (in_valid) begin
                odd_c0 <= conv_col[0];
                odd_r0 <= conv_row[0];
                idx0   <= PIW'(conv_col >> 1);
                last0  <= (conv_row == CW'(CD - 1)) && (conv_col == CW'(CD - 1));
                if (col == CW'(DIM - 1)) begin
                    col <= '0;
                    row <= (row == CW'(DIM - 1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // new window column: older rows from the line buffers, newest is the pixel
    always_comb begin
        for (int r = 0; r < K; r++) begin
            new_col[r] = pxl_in;
        end
        for (int r = 0; r < K - 1; r++) begin
            new_col[r] = line_buf[K-2-r][col];
        end
    end

    // line buffers and window shift only on accepted pixels
    always_ff @(posedge clk) begin
        if (in_valid) begin
            line_buf[0][col] <= pxl_in;
            for (int k = 1; k < K - 1; k++) begin
                line_buf[k][col] <= line_buf[k-1][col];
            end
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][K-1] <= new_col[r];
            end
        end
    end

    // stage 1: one registered signed product per tap
    always_ff @(posedge clk) begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                prod[r*K+c] <= PP'($signed(win[r][c])) *
                               PP'($signed(weights[(r*K+c)*WW +: WW]));
            end
        end
    end

    // adder tree, arithmetic shift, saturation and optional ReLU
    always_comb begin
        acc = '0;
        for (int i = 0; i < NT; i++) begin
            acc = acc + SW'(prod[i]);
        end
        shifted = acc >>> SHIFT;
        if ((&shifted[SW-1:OW-1]) || !(|shifted[SW-1:OW-1])) begin
            sat = shifted[OW-1:0];
        end else if (shifted[SW-1]) begin
            sat = {1'b1, {(OW-1){1'b0}}};
        end else begin
            sat = {1'b0, {(OW-1){1'b1}}};
        end
`ifdef CONV_RELU_EN
        if (sat[OW-1]) begin
            sat = '0;
        end
`else
`endif
    end

    // stage 2: register the scaled, saturated conv result
    always_ff @(posedge clk) begin
        conv_s2 <= sat;
    end

    // valid bits and pool tags follow their data through stages 1 and 2
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            odd_c1 <= 1'b0;
            odd_c2 <= 1'b0;
            odd_r1 <= 1'b0;
            odd_r2 <= 1'b0;
            idx1   <= '0;
            idx2   <= '0;
            last1  <= 1'b0;
            last2  <= 1'b0;
        end else begin
            v1     <= v0;
            v2     <= v1;
            odd_c1 <= odd_c0;
            odd_c2 <= odd_c1;
            odd_r1 <= odd_r0;
            odd_r2 <= odd_r1;
            idx1   <= idx0;
            idx2   <= idx1;
            last1  <= last0;
            last2  <= last1;
        end
    end

    // horizontal max against the held even column, then vertical max
    always_comb begin
        hmax = (conv_s2 > hold) ? conv_s2 : hold;
        pmax = (pool_row_buf[idx2] > hmax) ? pool_row_buf[idx2] : hmax;
    end

    // pool state: hold even columns, park horizontal maxima of even rows
    always_ff @(posedge clk) begin
        if (v2) begin
            if (!odd_c2) begin
                hold <= conv_s2;
            end else if (!odd_r2) begin
                pool_row_buf[idx2] <= hmax;
            end
        end
    end

    // stage 3: registered pooled output with its valid and frame marker
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pool_out   <= '0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid      <= 1'b0;
            frame_done <= 1'b0;
            if (v2 && odd_c2 && odd_r2) begin
                pool_out   <= pmax;
                valid      <= 1'b1;
                frame_done <= last2;
            end
        end
    end

endmodule
